// File: rtl/bitonic_sorting_folded.sv
// Folded bitonic sorter: one layer of N/2 compare-exchange units reused over
// all L*(L+1)/2 network stages. Keys carry labels; the sort direction is
// chosen per vector. Valid/ready handshakes on both sides.

// One compare-exchange unit. Element a is the lower index of the pair.
module bitonic_cas #(
  parameter int W      = 8,
  parameter int B      = 4,
  parameter int SIGNED = 0
) (
  input  logic         asc,
  input  logic [W-1:0] a_key,
  input  logic [W-1:0] b_key,
  input  logic [B-1:0] a_lab,
  input  logic [B-1:0] b_lab,
  output logic [W-1:0] o_a_key,
  output logic [W-1:0] o_b_key,
  output logic [B-1:0] o_a_lab,
  output logic [B-1:0] o_b_lab
);
  logic gt, lt, swap;

  generate
    if (SIGNED != 0) begin : g_signed
      assign gt = $signed(a_key) > $signed(b_key);
      assign lt = $signed(a_key) < $signed(b_key);
    end else begin : g_unsigned
      assign gt = a_key > b_key;
      assign lt = a_key < b_key;
    end
  endgenerate

  // Equal keys never swap, so ties keep their original order within a pair.
  assign swap    = asc ? gt : lt;
  assign o_a_key = swap ? b_key : a_key;
  assign o_b_key = swap ? a_key : b_key;
  assign o_a_lab = swap ? b_lab : a_lab;
  assign o_b_lab = swap ? a_lab : b_lab;
endmodule

module bitonic_sorting_folded #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LABEL_WIDTH   = LOG_INPUT_NUM,
  parameter int SIGNED        = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    x_valid,
  output logic                                    x_ready,
  input  logic                                    x_ascending,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  x,
  input  logic [LABEL_WIDTH*(2**LOG_INPUT_NUM)-1:0] x_label,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  y,
  output logic [LABEL_WIDTH*(2**LOG_INPUT_NUM)-1:0] y_label,
  output logic                                    y_valid,
  input  logic                                    y_ready
);
  localparam int L    = LOG_INPUT_NUM;
  localparam int N    = 2 ** L;
  localparam int HALF = N / 2;
  localparam int W    = DATA_WIDTH;
  localparam int B    = LABEL_WIDTH;
  localparam int CW   = $clog2(L + 2);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                state_q, state_d;
  logic [N-1:0][W-1:0]   key_q, key_d;
  logic [N-1:0][B-1:0]   lab_q, lab_d;
  logic                  asc_q, asc_d;
  logic [CW-1:0]         p_q, p_d, q_q, q_d;
  logic                  load;

  // Per-unit pair addressing and data for the current stage (p,q).
  logic [HALF-1:0][L-1:0] ia, ib;
  logic [HALF-1:0]        pasc;
  logic [HALF-1:0][W-1:0] ca_key, cb_key, ra_key, rb_key;
  logic [HALF-1:0][B-1:0] ca_lab, cb_lab, ra_lab, rb_lab;
  logic                   dbit;

  // Unit j handles element i = j with a zero inserted at bit q, and its partner i^(1<<q).
  always_comb begin
    dbit = 1'b0;
    for (int j = 0; j < HALF; j++) begin
      ia[j] = ((L'(j) >> q_q) << (q_q + CW'(1))) | (L'(j) & ((L'(1) << q_q) - L'(1)));
      ib[j] = ia[j] | (L'(1) << q_q);
      // Bit p of i flips the direction; at p=L that bit is 0 so the final merge uses asc_q.
      dbit = 1'b0;
      for (int b = 0; b < L; b++)
        if (p_q == CW'(b)) dbit = ia[j][b];
      pasc[j]   = asc_q ^ dbit;
      ca_key[j] = key_q[ia[j]];
      cb_key[j] = key_q[ib[j]];
      ca_lab[j] = lab_q[ia[j]];
      cb_lab[j] = lab_q[ib[j]];
    end
  end

  generate
    for (genvar g = 0; g < HALF; g++) begin : g_cas
      bitonic_cas #(.W(W), .B(B), .SIGNED(SIGNED)) u_cas (
        .asc     (pasc[g]),
        .a_key   (ca_key[g]),
        .b_key   (cb_key[g]),
        .a_lab   (ca_lab[g]),
        .b_lab   (cb_lab[g]),
        .o_a_key (ra_key[g]),
        .o_b_key (rb_key[g]),
        .o_a_lab (ra_lab[g]),
        .o_b_lab (rb_lab[g])
      );
    end
  endgenerate

  // FSM next state, stage writeback, counter stepping and handshake outputs.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    lab_d   = lab_q;
    asc_d   = asc_q;
    p_d     = p_q;
    q_d     = q_q;
    x_ready = 1'b0;
    y_valid = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        x_ready = 1'b1;
        load    = x_valid;
      end
      SORT: begin
        for (int j = 0; j < HALF; j++) begin
          key_d[ia[j]] = ra_key[j];
          key_d[ib[j]] = rb_key[j];
          lab_d[ia[j]] = ra_lab[j];
          lab_d[ib[j]] = rb_lab[j];
        end
        if (q_q == '0) begin
          p_d = p_q + CW'(1);
          q_d = p_q;
        end else begin
          q_d = q_q - CW'(1);
        end
        if (p_q == CW'(L) && q_q == '0) state_d = DONE;
      end
      DONE: begin
        y_valid = 1'b1;
        x_ready = y_ready;
        if (y_ready) begin
          load = x_valid;
          if (!x_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      key_d   = x;
      lab_d   = x_label;
      asc_d   = x_ascending;
      p_d     = CW'(1);
      q_d     = '0;
      state_d = SORT;
    end
  end

  // State and working registers; reset aborts any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      lab_q   <= '0;
      asc_q   <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      lab_q   <= lab_d;
      asc_q   <= asc_d;
      p_q     <= p_d;
      q_q     <= q_d;
    end
  end

  assign y       = key_q;
  assign y_label = lab_q;
endmodule

// File: tb/tb_bitonic_sorting_folded.sv
// Bench for bitonic_sorting_folded: an unsigned and a signed 8-input instance,
// expected results queued at accept and compared when y_valid appears.
module tb_bitonic_sorting_folded;
  logic        clk = 1'b0, rst = 1'b1;
  logic        xvu = 1'b0, xvs = 1'b0, xa = 1'b1, yr = 1'b0, sel = 1'b0;
  logic [63:0] x  = '0;
  logic [23:0] xl = '0;
  logic        u_xr, u_yv, s_xr, s_yv;
  logic [63:0] u_y, s_y;
  logic [23:0] u_yl, s_yl;
  logic        xr_o, yv_o;
  logic [63:0] y_o;
  logic [23:0] yl_o;
  int          nchk = 0, nfail = 0;

  typedef struct {
    logic [63:0] y;
    logic [23:0] yl;
    logic [63:0] x;
    bit          pair;
  } exp_t;
  exp_t sbq[$];

  localparam logic [23:0] LBL = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [63:0] T1X = {8'd2, 8'd4, 8'd1, 8'd6, 8'd0, 8'd7, 8'd3, 8'd5};
  localparam logic [63:0] ASY = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [23:0] ASL = {3'd2, 3'd4, 3'd0, 3'd6, 3'd1, 3'd7, 3'd5, 3'd3};
  localparam logic [63:0] DSY = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  localparam logic [23:0] DSL = {3'd3, 3'd5, 3'd7, 3'd1, 3'd6, 3'd0, 3'd4, 3'd2};

  always #5 clk = ~clk;

  bitonic_sorting_folded #(.LOG_INPUT_NUM(3), .DATA_WIDTH(8), .LABEL_WIDTH(3), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .x_valid(xvu), .x_ready(u_xr), .x_ascending(xa), .x(x),
    .x_label(xl), .y(u_y), .y_label(u_yl), .y_valid(u_yv), .y_ready(yr));

  bitonic_sorting_folded #(.LOG_INPUT_NUM(3), .DATA_WIDTH(8), .LABEL_WIDTH(3), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .x_valid(xvs), .x_ready(s_xr), .x_ascending(xa), .x(x),
    .x_label(xl), .y(s_y), .y_label(s_yl), .y_valid(s_yv), .y_ready(yr));

  assign xr_o = sel ? s_xr : u_xr;
  assign yv_o = sel ? s_yv : u_yv;
  assign y_o  = sel ? s_y  : u_y;
  assign yl_o = sel ? s_yl : u_yl;

  // Reference sort of eight bytes.
  function automatic logic [63:0] sort8(input logic [63:0] v, input bit asc, input bit sgn);
    int a[8];
    int t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = sgn ? int'($signed(v[i*8 +: 8])) : int'(v[i*8 +: 8]);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (asc ? (a[j] > a[j+1]) : (a[j] < a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(a[i]);
    return r;
  endfunction

  // Present a vector until accepted; queue its expectation on the accept edge.
  task automatic send(input logic [63:0] xv, input logic [23:0] lv, input bit asc, input exp_t e);
    int n;
    @(negedge clk);
    x = xv; xl = lv; xa = asc;
    if (sel) xvs = 1'b1; else xvu = 1'b1;
    n = 0;
    #1;
    while (!xr_o && n < 60) begin @(negedge clk); #1; n++; end
    if (n >= 60) begin nchk++; nfail++; $display("FAIL accept_timeout x_ready stuck at 0"); end
    sbq.push_back(e);
    @(posedge clk);
    #1 xvu = 1'b0; xvs = 1'b0;
    x = {$urandom, $urandom}; xl = 24'($urandom); xa = 1'($urandom);
  endtask

  // Negedges since the accept edge until y_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (yv_o) begin lat = n - 1; break; end
    end
  endtask

  task automatic consume();
    yr = 1'b1;
    @(posedge clk);
    #1 yr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nchk++; if (u_yv !== 1'b0) begin nfail++; $display("FAIL reset_u_y_valid got %b want 0", u_yv); end
    nchk++; if (u_xr !== 1'b1) begin nfail++; $display("FAIL reset_u_x_ready got %b want 1", u_xr); end
    nchk++; if (u_y !== 64'h0) begin nfail++; $display("FAIL reset_u_y got %h want 0", u_y); end
    nchk++; if (u_yl !== 24'h0) begin nfail++; $display("FAIL reset_u_y_label got %h want 0", u_yl); end
    nchk++; if (s_yv !== 1'b0) begin nfail++; $display("FAIL reset_s_y_valid got %b want 0", s_yv); end
    nchk++; if (s_xr !== 1'b1) begin nfail++; $display("FAIL reset_s_x_ready got %b want 1", s_xr); end
  endtask

  task automatic test_sort(input string nm, input bit s, input logic [63:0] xv, input logic [23:0] lv,
                           input bit asc, input logic [63:0] ey, input logic [23:0] eyl, input bit pair);
    exp_t e;
    int   lat, li;
    bit   ok;
    sel = s;
    e.y = ey; e.yl = eyl; e.x = xv; e.pair = pair;
    send(xv, lv, asc, e);
    wait_valid(lat);
    nchk++; if (lat !== 6) begin nfail++; $display("FAIL %s_latency got %0d want 6", nm, lat); end
    e = sbq.pop_front();
    nchk++; if (y_o !== e.y) begin nfail++; $display("FAIL %s_y got %h want %h", nm, y_o, e.y); end
    if (!e.pair) begin
      nchk++; if (yl_o !== e.yl) begin nfail++; $display("FAIL %s_y_label got %h want %h", nm, yl_o, e.yl); end
    end else begin
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        li = int'(yl_o[i*3 +: 3]);
        if (e.x[li*8 +: 8] !== y_o[i*8 +: 8]) ok = 1'b0;
      end
      nchk++; if (!ok) begin nfail++; $display("FAIL %s_label_pairing got y_label %h want labels matching keys of %h", nm, yl_o, e.x); end
    end
    consume();
  endtask

  task automatic test_back_to_back();
    exp_t e, e2;
    int   lat;
    sel = 1'b0;
    e.y = ASY; e.yl = ASL; e.x = T1X; e.pair = 1'b0;
    send(T1X, LBL, 1'b1, e);
    wait_valid(lat);
    nchk++; if (lat !== 6) begin nfail++; $display("FAIL bp_latency got %0d want 6", lat); end
    e = sbq.pop_front();
    for (int c = 0; c < 5; c++) begin
      nchk++; if (y_o !== e.y)   begin nfail++; $display("FAIL bp_hold_y got %h want %h", y_o, e.y); end
      nchk++; if (yl_o !== e.yl) begin nfail++; $display("FAIL bp_hold_y_label got %h want %h", yl_o, e.yl); end
      nchk++; if (xr_o !== 1'b0) begin nfail++; $display("FAIL bp_hold_x_ready got %b want 0", xr_o); end
      nchk++; if (yv_o !== 1'b1) begin nfail++; $display("FAIL bp_hold_y_valid got %b want 1", yv_o); end
      @(negedge clk);
    end
    yr = 1'b1; xvu = 1'b1; x = T1X; xl = LBL; xa = 1'b0;
    #1;
    nchk++; if (xr_o !== 1'b1) begin nfail++; $display("FAIL b2b_x_ready got %b want 1", xr_o); end
    e2.y = DSY; e2.yl = DSL; e2.x = T1X; e2.pair = 1'b0;
    sbq.push_back(e2);
    @(posedge clk);
    #1 yr = 1'b0; xvu = 1'b0;
    nchk++; if (yv_o !== 1'b0) begin nfail++; $display("FAIL b2b_consumed y_valid got %b want 0", yv_o); end
    wait_valid(lat);
    nchk++; if (lat !== 6) begin nfail++; $display("FAIL b2b_latency got %0d want 6", lat); end
    e = sbq.pop_front();
    nchk++; if (y_o !== e.y)   begin nfail++; $display("FAIL b2b_y got %h want %h", y_o, e.y); end
    nchk++; if (yl_o !== e.yl) begin nfail++; $display("FAIL b2b_y_label got %h want %h", yl_o, e.yl); end
    consume();
  endtask

  task automatic test_reset_midsort();
    exp_t e;
    sel = 1'b0;
    e.y = ASY; e.yl = ASL; e.x = T1X; e.pair = 1'b0;
    send(T1X, LBL, 1'b1, e);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    void'(sbq.pop_front());
    nchk++; if (yv_o !== 1'b0)   begin nfail++; $display("FAIL midrst_y_valid got %b want 0", yv_o); end
    nchk++; if (y_o !== 64'h0)   begin nfail++; $display("FAIL midrst_y got %h want 0", y_o); end
    nchk++; if (yl_o !== 24'h0)  begin nfail++; $display("FAIL midrst_y_label got %h want 0", yl_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nchk++; if (xr_o !== 1'b1) begin nfail++; $display("FAIL midrst_x_ready got %b want 1", xr_o); end
    repeat (3) @(negedge clk);
    nchk++; if (yv_o !== 1'b0) begin nfail++; $display("FAIL midrst_no_output got %b want 0", yv_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rv;
    bit          ra;
    rst = 1'b1;
    test_reset();
    @(negedge clk) rst = 1'b0;
    test_sort("t1_asc", 1'b0, T1X, LBL, 1'b1, ASY, ASL, 1'b0);
    test_sort("t2_desc", 1'b0, T1X, LBL, 1'b0, DSY, DSL, 1'b0);
    test_sort("t3_signed", 1'b1, {8'hF0, 8'h10, 8'hFE, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'h80}, LBL, 1'b1,
              {8'h7F, 8'h10, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hF0, 8'h80},
              {3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd5, 3'd7, 3'd0}, 1'b0);
    test_sort("t4_equal", 1'b0, {8{8'h2A}}, LBL, 1'b1, {8{8'h2A}}, LBL, 1'b0);
    test_sort("t4_equal_desc", 1'b0, {8{8'h2A}}, LBL, 1'b0, {8{8'h2A}}, LBL, 1'b0);
    test_back_to_back();
    test_reset_midsort();
    test_sort("t6_after_reset", 1'b0, T1X, LBL, 1'b1, ASY, ASL, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rv = {$urandom, $urandom};
      ra = 1'($urandom);
      test_sort("rand_u", 1'b0, rv, LBL, ra, sort8(rv, ra, 1'b0), LBL, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      rv = {$urandom, $urandom};
      ra = 1'($urandom);
      test_sort("rand_s", 1'b1, rv, LBL, ra, sort8(rv, ra, 1'b1), LBL, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
